spi_req_arbiter: RTL and testbench

//  Shares one SPI byte engine between NREQ requesters: round-robin grant, per-requester chip select,

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_rr_arbiter.sv | 37 +++
 rtl/spi_req_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter: FSM state encoding,
// timer width and index-width helper.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CSS  = 3'd1,
    ST_LOAD = 3'd2,
    ST_XFER = 3'd3,
    ST_HOLD = 3'd4,
    ST_GAP  = 3'd5
  } arb_state_e;

  // One timer serves CS setup, hold, gap and the LOAD watchdog.
  localparam int TMR_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin picker: the first active request strictly after the last grant
// (wrapping) wins, so the last granted requester has the lowest priority.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  logic found_s;
  int   cand_s;

  // Scan NREQ positions starting just above the last grant.
  always_comb begin
    found_s   = 1'b0;
    cand_s    = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = last_i;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(last_i) + k) % NREQ;
      if (!found_s && req_i[cand_s]) begin
        found_s          = 1'b1;
        gnt_oh_o[cand_s] = 1'b1;
        gnt_idx_o        = IDX_W'(cand_s);
      end
    end
  end

  assign gnt_any_o = |req_i;

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI byte engine between NREQ requesters with round-robin grant,
// per-requester chip select and multi-byte bursts. Optional LOAD watchdog: SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int LEN_W       = 8,
  parameter int CSS         = 2,
  parameter int CSH         = 2,
  parameter int GAP         = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     tx_data,
  input  logic [NREQ-1:0]       tx_valid,
  output logic [NREQ-1:0]       tx_ready,
  output logic [7:0]            rx_data,
  output logic [NREQ-1:0]       rx_valid,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic                  busy,
  output logic                  eng_start,
  output logic [7:0]            eng_txd,
  input  logic                  eng_done,
  input  logic [7:0]            eng_rxd,
  output logic [NREQ-1:0]       cs_n
);

  localparam int IDX_W = idx_width(NREQ);
  localparam logic [TMR_W-1:0] CSS_LAST = TMR_W'(CSS - 1);
  localparam logic [TMR_W-1:0] CSH_LAST = TMR_W'(CSH - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP > 0) ? GAP - 1 : 0);
  localparam arb_state_e LEAVE_ST = (GAP > 0) ? ST_GAP : ST_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
`endif

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, last_q, last_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NREQ-1:0]    grant_q, grant_d, cs_n_q, cs_n_d, tx_ready_q, tx_ready_d;
  logic [NREQ-1:0]    rx_valid_q, rx_valid_d, done_q, done_d;
  logic [7:0]         rx_data_q, rx_data_d, eng_txd_q, eng_txd_d;
  logic               busy_q, busy_d, eng_start_q, eng_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [NREQ-1:0]    err_q, err_d;
`endif

  logic [NREQ-1:0]    pick_oh_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [7:0]         tx_arr_s  [NREQ];
  logic [LEN_W-1:0]   len_arr_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign tx_arr_s[g]  = tx_data[g*8 +: 8];
    assign len_arr_s[g] = req_len[g*LEN_W +: LEN_W];
  end

  spi_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (req),
    .last_i    (last_q),
    .gnt_oh_o  (pick_oh_s),
    .gnt_idx_o (pick_idx_s),
    .gnt_any_o (pick_any_s)
  );

  // Next-state, timers, byte counter and registered output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    grant_d     = grant_q;
    rx_data_d   = rx_data_q;
    eng_txd_d   = eng_txd_q;
    eng_start_d = 1'b0;
    rx_valid_d  = '0;
    done_d      = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d = ST_CSS;
          idx_d   = pick_idx_s;
          last_d  = pick_idx_s;
          grant_d = pick_oh_s;
          len_d   = len_arr_s[pick_idx_s];
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CSS: begin
        if (tmr_q == CSS_LAST) begin
          state_d = ST_LOAD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_LOAD: begin
        if (tx_valid[idx_q]) begin
          state_d     = ST_XFER;
          eng_start_d = 1'b1;
          eng_txd_d   = tx_arr_s[idx_q];
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmr_q == TO_LAST) begin
          state_d       = LEAVE_ST;
          grant_d       = '0;
          err_d[idx_q]  = 1'b1;
          tmr_d         = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
`else
        else begin
          state_d = ST_LOAD;
        end
`endif
      end
      ST_XFER: begin
        if (eng_done) begin
          rx_valid_d[idx_q] = 1'b1;
          rx_data_d         = eng_rxd;
          cnt_d             = cnt_q + (LEN_W+1)'(1);
          tmr_d             = '0;
          // cnt_d now holds bytes completed; burst is len+1 bytes long.
          if (cnt_d == ({1'b0, len_q} + (LEN_W+1)'(1))) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_HOLD: begin
        if (tmr_q == CSH_LAST) begin
          state_d       = LEAVE_ST;
          grant_d       = '0;
          done_d[idx_q] = 1'b1;
          tmr_d         = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    cs_n_d     = ~grant_d;
    tx_ready_d = (state_d == ST_LOAD) ? grant_d : '0;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      grant_q     <= '0;
      cs_n_q      <= '1;
      tx_ready_q  <= '0;
      rx_valid_q  <= '0;
      done_q      <= '0;
      rx_data_q   <= 8'h00;
      eng_txd_q   <= 8'h00;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      grant_q     <= grant_d;
      cs_n_q      <= cs_n_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      eng_txd_q   <= eng_txd_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign cs_n      = cs_n_q;
  assign tx_ready  = tx_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_txd   = eng_txd_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = '0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter; inputs driven and outputs
// sampled on the falling clock edge.
module tb_spi_req_arbiter;

  localparam int NREQ = 4, LEN_W = 8, CSS = 2, CSH = 2, GAP = 1;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16, STALL = 10;
`else
  localparam int TO = 1024, STALL = 50;
`endif

  logic                  PCLK, PRESET;
  logic [NREQ-1:0]       req, tx_valid, tx_ready, rx_valid, grant, done, err, cs_n;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     tx_data;
  logic [7:0]            rx_data, eng_txd, eng_rxd;
  logic                  busy, eng_start, eng_done;
  int checks = 0;
  int errors = 0;

  spi_req_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .CSS(CSS), .CSH(CSH), .GAP(GAP),
                    .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_len(req_len), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .grant(grant), .done(done), .err(err), .busy(busy), .eng_start(eng_start),
    .eng_txd(eng_txd), .eng_done(eng_done), .eng_rxd(eng_rxd), .cs_n(cs_n)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(negedge PCLK);
  endtask

  task automatic test_reset;
    PRESET = 1'b1; req = '0; req_len = '0; tx_data = '0; tx_valid = '0;
    eng_done = 1'b0; eng_rxd = 8'h00;
    tick; tick;
    PRESET = 1'b0;
    tick;
    checks++;
    if ({grant, tx_ready, rx_valid, done, err, busy, eng_start, eng_txd, rx_data, cs_n} !==
        {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 4'hF}) begin
      errors++;
      $display("FAIL reset: grant=%b cs_n=%b busy=%b eng_start=%b, expected 0000/1111/0/0",
               grant, cs_n, busy, eng_start);
    end
  endtask

  task automatic wait_grant(input logic [3:0] exp, input int exp_wait);
    int n = 0;
    do begin tick; n++; end while (grant == 4'h0 && n < 20);
    checks++;
    if (grant !== exp || n != exp_wait) begin
      errors++;
      $display("FAIL grant: got %b after %0d cycles, expected %b after %0d", grant, n, exp, exp_wait);
    end
  endtask

  // Starts in the first CSS cycle; runs nb bytes with an optional LOAD stall before byte 0.
  task automatic do_frame(input int who, input int nb, input logic [7:0] base, input int stall);
    logic [3:0] oh;
    logic [7:0] b;
    oh = 4'b0001 << who;
    for (int s = 0; s < CSS - 1; s++) begin
      tick; checks++;
      if (tx_ready !== 4'h0 || cs_n !== ~oh) begin
        errors++; $display("FAIL css: tx_ready=%b cs_n=%b, expected 0000/%b", tx_ready, cs_n, ~oh);
      end
    end
    tick; checks++;
    if (tx_ready !== oh || cs_n !== ~oh) begin
      errors++; $display("FAIL css_end: tx_ready=%b cs_n=%b, expected %b/%b", tx_ready, cs_n, oh, ~oh);
    end
    for (int k = 0; k < nb; k++) begin
      b = base + 8'(k);
      for (int s = 0; s < (k == 0 ? stall : 0); s++) begin
        eng_done = (s == 2); eng_rxd = 8'hFF;
        tick; eng_done = 1'b0; checks++;
        if (eng_start !== 1'b0 || rx_valid !== 4'h0 || tx_ready !== oh || cs_n !== ~oh) begin
          errors++;
          $display("FAIL stall: cyc %0d eng_start=%b rx_valid=%b tx_ready=%b cs_n=%b, expected 0/0000/%b/%b",
                   s, eng_start, rx_valid, tx_ready, cs_n, oh, ~oh);
        end
      end
      tx_data[who*8 +: 8] = b; tx_valid[who] = 1'b1;
      tick; tx_valid = '0; checks++;
      if (eng_start !== 1'b1 || eng_txd !== b || tx_ready !== 4'h0) begin
        errors++;
        $display("FAIL start: eng_start=%b eng_txd=%h tx_ready=%b, expected 1/%h/0000",
                 eng_start, eng_txd, tx_ready, b);
      end
      eng_done = 1'b1; eng_rxd = b ^ 8'h99;
      tick; eng_done = 1'b0; checks++;
      if (rx_valid !== oh || rx_data !== (b ^ 8'h99) || eng_start !== 1'b0 || cs_n !== ~oh) begin
        errors++;
        $display("FAIL rx: rx_valid=%b rx_data=%h eng_start=%b cs_n=%b, expected %b/%h/0/%b",
                 rx_valid, rx_data, eng_start, cs_n, oh, b ^ 8'h99, ~oh);
      end
      if (k < nb - 1) begin
        checks++;
        if (tx_ready !== oh) begin
          errors++; $display("FAIL reload: tx_ready=%b, expected %b", tx_ready, oh);
        end
      end
    end
    for (int s = 0; s < CSH - 1; s++) begin
      tick; checks++;
      if (done !== 4'h0 || cs_n !== ~oh) begin
        errors++; $display("FAIL hold: done=%b cs_n=%b, expected 0000/%b", done, cs_n, ~oh);
      end
    end
    tick; checks++;
    if (done !== oh || cs_n !== 4'hF || grant !== 4'h0 || err !== 4'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done: done=%b cs_n=%b grant=%b err=%b busy=%b, expected %b/1111/0000/0000/1",
               done, cs_n, grant, err, busy, oh);
    end
  endtask

  task automatic test_single;
    tick; req = 4'b0001; req_len = '0;
    wait_grant(4'b0001, 1);
    req = '0;
    do_frame(0, 1, 8'hA5, 0);
    tick; checks++;
    if (busy !== 1'b0 || done !== 4'h0) begin
      errors++; $display("FAIL idle_after: busy=%b done=%b, expected 0/0000", busy, done);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    test_reset;
    req = 4'hF; req_len = '0;
    wait_grant(4'b0001, 1);
    do_frame(0, 1, 8'h10, 0);
    for (int g = 1; g <= 4; g++) begin
      exp = 4'b0001 << (g % 4);
      wait_grant(exp, GAP + 1);
      do_frame(g % 4, 1, 8'h10 + 8'(g), 0);
    end
    req = '0;
  endtask

  task automatic test_burst;
    tick; req = 4'b0100; req_len = '0; req_len[2*LEN_W +: LEN_W] = 8'd3;
    wait_grant(4'b0100, 1);
    req = '0;
    do_frame(2, 4, 8'h01, 0);
    tick;
  endtask

  task automatic test_stall;
    tick; req = 4'b0010; req_len = '0;
    wait_grant(4'b0010, 1);
    req = '0;
    do_frame(1, 1, 8'h5A, STALL);
    tick;
  endtask

  task automatic test_reset_mid;
    tick; req = 4'b1000;
    wait_grant(4'b1000, 1);
    req = '0;
    repeat (CSS) tick;
    tx_valid[3] = 1'b1;
    tick; tx_valid = '0; checks++;
    if (eng_start !== 1'b1) begin
      errors++; $display("FAIL pre_reset_start: eng_start=%b, expected 1", eng_start);
    end
    PRESET = 1'b1;
    tick; checks++;
    if (cs_n !== 4'hF || grant !== 4'h0 || busy !== 1'b0 || done !== 4'h0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cs_n=%b grant=%b busy=%b done=%b, expected 1111/0000/0/0000",
               cs_n, grant, busy, done);
    end
    PRESET = 1'b0;
    for (int s = 0; s < 3; s++) begin
      eng_done = (s == 0); eng_rxd = 8'h42;
      tick; eng_done = 1'b0; checks++;
      if (done !== 4'h0 || busy !== 1'b0 || rx_valid !== 4'h0) begin
        errors++; $display("FAIL post_reset: done=%b busy=%b rx_valid=%b, expected 0000/0/0000",
                           done, busy, rx_valid);
      end
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    tick; req = 4'b0001; req_len = '0;
    wait_grant(4'b0001, 1);
    req = 4'b0010;
    repeat (CSS) tick;
    for (int s = 0; s < TO - 1; s++) begin
      tick; checks++;
      if (err !== 4'h0 || tx_ready !== 4'b0001) begin
        errors++; $display("FAIL to_wait: cyc %0d err=%b tx_ready=%b, expected 0000/0001", s, err, tx_ready);
      end
    end
    tick; checks++;
    if (err !== 4'b0001 || done !== 4'h0 || cs_n !== 4'hF || grant !== 4'h0) begin
      errors++;
      $display("FAIL timeout: err=%b done=%b cs_n=%b grant=%b, expected 0001/0000/1111/0000",
               err, done, cs_n, grant);
    end
    wait_grant(4'b0010, GAP + 1);
    req = '0;
    do_frame(1, 1, 8'h77, 0);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_burst;
    test_stall;
    test_reset_mid;
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units, expected to finish");
    $fatal(1);
  end

endmodule
